// File: rtl/simple_cpu_arb_pkg.sv
// simple_cpu_arb_pkg: sequencer state encoding and default watchdog limit for simple_cpu_job_arbiter
package simple_cpu_arb_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LAUNCH = 3'd2,
    RUN    = 3'd3,
    RESP   = 3'd4
  } state_t;
  localparam int WDT_CYCLES_DEF = 1024;
endpackage

// File: rtl/simple_cpu_job_arbiter_rr_arbiter.sv
// rr_arbiter: picks the first request at or above ptr (with wrap) as a one-hot grant plus index
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);
  logic [ID_W:0]   s;
  logic [ID_W-1:0] j;
  // scan from the farthest candidate back to ptr so the nearest request wins
  always_comb begin
    gnt = '0;
    idx = '0;
    s   = '0;
    j   = '0;
    any = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (ID_W+1)'(k);
      j = (s >= (ID_W+1)'(NUM_REQ)) ? ID_W'(s - (ID_W+1)'(NUM_REQ)) : ID_W'(s);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
endmodule

// File: rtl/simple_cpu_job_arbiter.sv
// simple_cpu_job_arbiter: round-robin job sequencer sharing one simple_cpu_top; SIMPLE_CPU_ARB_WDT_EN enables the RUN watchdog
module simple_cpu_job_arbiter
  import simple_cpu_arb_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int WDT_CYCLES = WDT_CYCLES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [BIT_WIDTH-1:0]         rsp_result,
  output logic                         rsp_err,
  output logic                         cpu_rst_n,
  output logic                         cpu_start,
  output logic [BIT_WIDTH-1:0]         cpu_operand_a,
  output logic [BIT_WIDTH-1:0]         cpu_operand_b,
  input  logic [BIT_WIDTH-1:0]         cpu_result,
  input  logic                         cpu_done,
  output logic                         busy
);
  state_t              state, state_nx;
  logic [ID_W-1:0]     rr_ptr, g_idx;
  logic [NUM_REQ-1:0]  g_vec;
  logic                g_any, wdt_hit, grant, finish;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(g_vec),
    .idx(g_idx),
    .any(g_any)
  );

`ifdef SIMPLE_CPU_ARB_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_cnt;
  // count RUN cycles of the current job; cleared outside RUN
  always_ff @(posedge clk) begin
    if (rst || state != RUN) wdt_cnt <= '0;
    else wdt_cnt <= wdt_cnt + 1'b1;
  end
  assign wdt_hit = state == RUN && !cpu_done && wdt_cnt == WDT_W'(WDT_CYCLES - 1);
`else
  assign wdt_hit = 1'b0;
`endif

  assign grant     = state == IDLE && g_any;
  assign finish    = state == RUN && (cpu_done || wdt_hit);
  assign req_ready = (state == IDLE && !rst) ? g_vec : '0;
  assign rsp_valid = state == RESP;
  assign cpu_rst_n = state != CLEAR;
  assign cpu_start = state == LAUNCH;
  assign busy      = state != IDLE;

  // job sequence: grant, clear CPU, start it, wait for done, hold response until taken
  always_comb begin
    state_nx = state == IDLE   ? (g_any ? CLEAR : IDLE) :
               state == CLEAR  ? LAUNCH :
               state == LAUNCH ? RUN :
               state == RUN    ? (finish ? RESP : RUN) :
               state == RESP   ? (rsp_ready ? IDLE : RESP) : IDLE;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end

  // latch the granted job at grant and its outcome when RUN ends
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr        <= '0;
      rsp_id        <= '0;
      rsp_result    <= '0;
      rsp_err       <= 1'b0;
      cpu_operand_a <= '0;
      cpu_operand_b <= '0;
    end else begin
      if (grant) begin
        rr_ptr        <= (g_idx == ID_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
        rsp_id        <= g_idx;
        cpu_operand_a <= req_a[g_idx*BIT_WIDTH +: BIT_WIDTH];
        cpu_operand_b <= req_b[g_idx*BIT_WIDTH +: BIT_WIDTH];
      end
      if (finish) begin
        rsp_result <= cpu_done ? cpu_result : '0;
        rsp_err    <= wdt_hit;
      end
    end
  end
endmodule

// File: tb/tb_simple_cpu_job_arbiter.sv
// tb_simple_cpu_job_arbiter: scoreboard bench with a behavioural CPU model for simple_cpu_job_arbiter
module tb_simple_cpu_job_arbiter;
  localparam int BW = 16;
  localparam int NR = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [NR*BW-1:0] req_a = '0;
  logic [NR*BW-1:0] req_b = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [IW-1:0] rsp_id;
  logic [BW-1:0] rsp_result;
  logic rsp_err, cpu_rst_n, cpu_start, busy;
  logic [BW-1:0] opa, opb;
  logic [BW-1:0] cpu_result = '0;
  logic cpu_done = 1'b0;

  always #5 clk = ~clk;

  simple_cpu_job_arbiter #(.BIT_WIDTH(BW), .NUM_REQ(NR), .ID_W(IW), .WDT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .cpu_rst_n(cpu_rst_n), .cpu_start(cpu_start),
    .cpu_operand_a(opa), .cpu_operand_b(opb),
    .cpu_result(cpu_result), .cpu_done(cpu_done), .busy(busy)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [BW-1:0] res;
    logic          err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t e;
  int gnt_q[$];
  int jobs_left[NR];
  bit drop[NR];
  int checks = 0;
  int fails = 0;
  int rstn_lows = 0;
  int starts = 0;
  int mcnt = 0;
  bit hang = 0;
  logic [BW-1:0] pend;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(int i, logic [BW-1:0] a, logic [BW-1:0] b, int n);
    req_a[i*BW +: BW] = a;
    req_b[i*BW +: BW] = b;
    jobs_left[i] = n;
    req_valid[i] = 1'b1;
  endtask

  task automatic exp_rsp(logic [IW-1:0] id, logic [BW-1:0] r, logic er);
    exp_q.push_back('{id: id, res: r, err: er});
  endtask

  task automatic wait_idle(string name);
    bit ok = 0;
    repeat (300) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && req_valid == '0) begin
        ok = 1;
        break;
      end
    end
    chk({name, "_complete"}, 32'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(string name);
    chk({name, "_req_ready"}, 32'(req_ready), 0);
    chk({name, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({name, "_rsp_id"}, 32'(rsp_id), 0);
    chk({name, "_rsp_result"}, 32'(rsp_result), 0);
    chk({name, "_rsp_err"}, 32'(rsp_err), 0);
    chk({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 1);
    chk({name, "_cpu_start"}, 32'(cpu_start), 0);
    chk({name, "_opa"}, 32'(opa), 0);
    chk({name, "_opb"}, 32'(opb), 0);
    chk({name, "_busy"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    hang = 0;
    for (int i = 0; i < NR; i++) jobs_left[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    gnt_q.delete();
    rstn_lows = 0;
    starts = 0;
  endtask

  // CPU model: done 3 cycles after start with result a+b; done sticky until cpu_rst_n low
  initial forever begin
    @(negedge clk);
    if (!cpu_rst_n) rstn_lows++;
    if (cpu_start) starts++;
    if (!cpu_rst_n) begin
      cpu_done = 1'b0;
      cpu_result = '0;
      mcnt = 0;
    end else if (cpu_start) begin
      mcnt = hang ? 0 : 3;
      pend = opa + opb;
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        cpu_done = 1'b1;
        cpu_result = pend;
      end
    end
  end

  // monitor: log grants, retire finished requesters, score responses on handshake
  initial forever begin
    @(negedge clk);
    if (|req_ready) begin
      chk("req_ready_onehot", 32'($onehot(req_ready)), 1);
      for (int i = 0; i < NR; i++) if (req_ready[i]) begin
        gnt_q.push_back(i);
        if (jobs_left[i] > 0) jobs_left[i]--;
        if (jobs_left[i] == 0) drop[i] = 1;
      end
    end
    if (rsp_valid) chk("no_grant_during_resp", 32'(|req_ready), 0);
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_rsp: got id %0d result %0h err %0d, expected none", rsp_id, rsp_result, rsp_err);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_result", 32'(rsp_result), 32'(e.res));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (drop[i]) begin
      req_valid[i] = 1'b0;
      drop[i] = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_check("reset");
    @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b0;
    gnt_q.delete();
    rstn_lows = 0;
    starts = 0;

    issue(1, 16'd7, 16'd5, 1);
    exp_rsp(2'd1, 16'd12, 1'b0);
    wait_idle("t1");
    chk("t1_grants", 32'(gnt_q.size()), 1);
    chk("t1_grant_id", 32'(gnt_q[0]), 1);
    chk("t1_rstn_lows", 32'(rstn_lows), 1);
    chk("t1_starts", 32'(starts), 1);

    do_reset();
    issue(0, 16'h0001, 16'h0002, 2);
    issue(1, 16'h0010, 16'h0003, 1);
    issue(2, 16'h0100, 16'h0022, 1);
    issue(3, 16'hFFFF, 16'h0002, 1);
    exp_rsp(2'd0, 16'h0003, 1'b0);
    exp_rsp(2'd1, 16'h0013, 1'b0);
    exp_rsp(2'd2, 16'h0122, 1'b0);
    exp_rsp(2'd3, 16'h0001, 1'b0);
    exp_rsp(2'd0, 16'h0003, 1'b0);
    wait_idle("t2");
    chk("t2_grants", 32'(gnt_q.size()), 5);
    chk("t2_g0", 32'(gnt_q[0]), 0);
    chk("t2_g1", 32'(gnt_q[1]), 1);
    chk("t2_g2", 32'(gnt_q[2]), 2);
    chk("t2_g3", 32'(gnt_q[3]), 3);
    chk("t2_g4", 32'(gnt_q[4]), 0);

    rsp_ready = 1'b0;
    issue(2, 16'd100, 16'd23, 1);
    issue(3, 16'h1234, 16'h1111, 1);
    exp_rsp(2'd2, 16'd123, 1'b0);
    exp_rsp(2'd3, 16'h2345, 1'b0);
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        break;
      end
    end
    chk("t3_rsp_seen", 32'(seen), 1);
    repeat (10) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(rsp_valid), 1);
      chk("t3_hold_id", 32'(rsp_id), 2);
      chk("t3_hold_result", 32'(rsp_result), 123);
      chk("t3_hold_no_ready", 32'(req_ready), 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_idle("t3");

    rstn_lows = 0;
    starts = 0;
    issue(0, 16'd1, 16'd2, 1);
    exp_rsp(2'd0, 16'd3, 1'b0);
    wait_idle("t4a");
    issue(1, 16'd40, 16'd2, 1);
    exp_rsp(2'd1, 16'd42, 1'b0);
    wait_idle("t4b");
    chk("t4_rstn_lows", 32'(rstn_lows), 2);
    chk("t4_starts", 32'(starts), 2);

    issue(3, 16'd5, 16'd6, 1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (cpu_start) begin
        seen = 1;
        break;
      end
    end
    chk("t5_launch_seen", 32'(seen), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid[3] = 1'b0;
    jobs_left[3] = 0;
    @(posedge clk);
    #1;
    reset_check("t5_abort");
    rst = 1'b0;
    gnt_q.delete();
    issue(1, 16'd9, 16'd9, 1);
    exp_rsp(2'd1, 16'd18, 1'b0);
    wait_idle("t5");
    chk("t5_grants", 32'(gnt_q.size()), 1);
    chk("t5_grant_id", 32'(gnt_q[0]), 1);

    hang = 1;
    issue(0, 16'd3, 16'd4, 1);
`ifdef SIMPLE_CPU_ARB_WDT_EN
    exp_rsp(2'd0, 16'd0, 1'b1);
    wait_idle("t6_wdt");
`else
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("t6_no_rsp", 32'(seen), 0);
    chk("t6_still_busy", 32'(busy), 1);
    chk("t6_err_low", 32'(rsp_err), 0);
`endif
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
